// File: rtl/f_add_arbiter.sv
// rtl/f_add_arbiter.sv - round-robin arbiter feeding one shared single-precision adder
// Two-stage pipe: S1 holds the granted operands for F_add, S2 holds the tagged result.

module F_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rounding,
  output logic [31:0] y,
  output logic        flags [4:0]
);
  logic [7:0]  ea, eb, el, es;
  logic [23:0] ml, ms;
  logic [9:0]  el_eff, es_eff, d, ex, ex_r;
  logic [26:0] sm, n;
  logic [27:0] s;
  logic [53:0] wide;
  logic [4:0]  lz, shamt, fl;
  logic [24:0] mr;
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic        swap, sub, sl, rbit, stk, inexact, up, tiny, max_fin;

  always_comb begin
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (&ea) && (|a[22:0]);
    b_nan  = (&eb) && (|b[22:0]);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf  = (&ea) && !(|a[22:0]);
    b_inf  = (&eb) && !(|b[22:0]);
    sub    = a[31] ^ b[31];

    swap   = b[30:0] > a[30:0];
    sl     = swap ? b[31] : a[31];
    el     = swap ? eb : ea;
    es     = swap ? ea : eb;
    ml     = swap ? {|eb, b[22:0]} : {|ea, a[22:0]};
    ms     = swap ? {|ea, a[22:0]} : {|eb, b[22:0]};
    el_eff = (el == 8'd0) ? 10'd1 : {2'b0, el};
    es_eff = (es == 8'd0) ? 10'd1 : {2'b0, es};
    d      = el_eff - es_eff;

    // Align the smaller operand; bits shifted out fold into a sticky LSB.
    wide = {ms, 30'b0} >> d;
    if (d > 10'd26) sm = {26'b0, |ms};
    else            sm = {wide[53:28], wide[27] | (|wide[26:0])};

    s = sub ? ({1'b0, ml, 3'b0} - {1'b0, sm}) : ({1'b0, ml, 3'b0} + {1'b0, sm});

    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end
    shamt = ({5'b0, lz} < el_eff) ? lz : 5'(el_eff - 10'd1);

    if (s[27]) begin
      n  = {s[27:2], s[1] | s[0]};
      ex = el_eff + 10'd1;
    end else begin
      n  = s[26:0] << shamt;
      ex = el_eff - {5'b0, shamt};
    end

    tiny    = !n[26];
    rbit    = n[2];
    stk     = |n[1:0];
    inexact = rbit | stk;
    case (rounding)
      3'd1:    up = 1'b0;
      3'd2:    up = inexact & sl;
      3'd3:    up = inexact & ~sl;
      3'd4:    up = rbit;
      default: up = rbit & (stk | n[3]);
    endcase
    mr   = {1'b0, n[26:3]} + {24'b0, up};
    // A subnormal that rounds up into bit 23 becomes the smallest normal.
    ex_r = mr[24] ? (ex + 10'd1) : (mr[23] ? ex : 10'd0);

    y  = {sl, ex_r[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    fl = {3'b000, tiny & inexact, inexact};
    max_fin = (rounding == 3'd1) || (rounding == 3'd2 && !sl) || (rounding == 3'd3 && sl);
    if (ex_r >= 10'd255) begin
      fl = 5'b00101;
      y  = max_fin ? {sl, 31'h7F7FFFFF} : {sl, 31'h7F800000};
    end
    if (s == 28'd0) begin
      y  = {sub ? (rounding == 3'd2) : sl, 31'b0};
      fl = 5'b0;
    end
    if (a_inf || b_inf) begin
      if (a_inf && b_inf && sub) begin
        y  = 32'h7FC00000;
        fl = 5'b10000;
      end else begin
        y  = {a_inf ? a[31] : b[31], 31'h7F800000};
        fl = 5'b0;
      end
    end
    if (a_nan || b_nan) begin
      y  = 32'h7FC00000;
      fl = {a_snan | b_snan, 4'b0};
    end

    for (int i = 0; i < 5; i++) flags[i] = fl[i];
  end
endmodule

module f_add_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  input  logic [N*3-1:0]    req_rm,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [31:0]       resp_y,
  output logic [4:0]        resp_flags,
  output logic              busy
);
  logic           v1_q, v1_d, v2_q, v2_d;
  logic [IDW-1:0] id1_q, id1_d, id2_q, id2_d, ptr_q, ptr_d, gnt_idx;
  logic [31:0]    a1_q, a1_d, b1_q, b1_d, y2_q, y2_d, add_y;
  logic [2:0]     rm1_q, rm1_d;
  logic [4:0]     flags2_q, flags2_d;
  logic           add_flags [4:0];
  logic           adv1, adv2, gnt_found, accept;
  int             cand;

  F_add u_add (
    .a        (a1_q),
    .b        (b1_q),
    .rounding (rm1_q),
    .y        (add_y),
    .flags    (add_flags)
  );

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_q) + k) % N;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

  always_comb begin
    adv2   = !v2_q || resp_ready;
    adv1   = !v1_q || adv2;
    accept = !reset && adv1 && gnt_found;
    for (int i = 0; i < N; i++) req_ready[i] = accept && (gnt_idx == IDW'(i));
  end

  always_comb begin
    v1_d     = v1_q;
    id1_d    = id1_q;
    a1_d     = a1_q;
    b1_d     = b1_q;
    rm1_d    = rm1_q;
    ptr_d    = ptr_q;
    v2_d     = v2_q;
    id2_d    = id2_q;
    y2_d     = y2_q;
    flags2_d = flags2_q;
    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        id1_d = gnt_idx;
        a1_d  = req_a[32*int'(gnt_idx) +: 32];
        b1_d  = req_b[32*int'(gnt_idx) +: 32];
        rm1_d = req_rm[3*int'(gnt_idx) +: 3];
        ptr_d = gnt_idx;
      end
    end
    if (adv2) begin
      v2_d     = v1_q;
      id2_d    = id1_q;
      y2_d     = add_y;
      flags2_d = {add_flags[4], add_flags[3], add_flags[2], add_flags[1], add_flags[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      id1_q    <= '0;
      a1_q     <= 32'h0;
      b1_q     <= 32'h0;
      rm1_q    <= 3'h0;
      ptr_q    <= IDW'(N - 1);
      v2_q     <= 1'b0;
      id2_q    <= '0;
      y2_q     <= 32'h0;
      flags2_q <= 5'h0;
    end else begin
      v1_q     <= v1_d;
      id1_q    <= id1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      rm1_q    <= rm1_d;
      ptr_q    <= ptr_d;
      v2_q     <= v2_d;
      id2_q    <= id2_d;
      y2_q     <= y2_d;
      flags2_q <= flags2_d;
    end
  end

  assign resp_valid = v2_q;
  assign resp_id    = id2_q;
  assign resp_y     = y2_q;
  assign resp_flags = flags2_q;
  assign busy       = v1_q | v2_q;
endmodule
